// File: rtl/approx_err_monitor_if.sv
// Signal bundle between the error monitor and the approximate multiplier
// under test. The environment side also supplies the start pulse and reads
// back the results.
interface approx_err_monitor_if;
  logic        start;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic [15:0] approx_y;
  logic        busy;
  logic        done;
  logic [16:0] err_count;
  logic [31:0] sum_ed;
  logic [15:0] max_ed;
  logic [7:0]  max_a;
  logic [7:0]  max_b;

  modport master (
    input  start, approx_y,
    output op_a, op_b, busy, done, err_count, sum_ed, max_ed, max_a, max_b
  );

  modport slave (
    output start, approx_y,
    input  op_a, op_b, busy, done, err_count, sum_ed, max_ed, max_a, max_b
  );
endinterface

// File: rtl/approx_err_monitor.sv
// Exhaustive error characterisation of an external 8x8 approximate multiplier.
// Sweeps all 65536 operand pairs, compares the returned product against the
// exact one and accumulates mismatch count, summed error distance and the
// worst-case error with the operands that first produced it.
//
// state | meaning
// IDLE  | reset state, waiting for start, results hold 0
// RUN   | sweeping operands, one vector per cycle, stage-2 accumulating
// DRAIN | accumulate the last vector of the sweep
// DONE  | results stable, a new start re-runs the sweep
module approx_err_monitor (
  input  logic                        clk,
  input  logic                        rst_n,
  approx_err_monitor_if.master        bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] idx;
  logic        busy_q;
  logic        done_q;

  logic        s1_valid;
  logic        s1_mis;
  logic [15:0] s1_ed;
  logic [7:0]  s1_a;
  logic [7:0]  s1_b;

  logic [16:0] err_count_q;
  logic [31:0] sum_ed_q;
  logic [15:0] max_ed_q;
  logic [7:0]  max_a_q;
  logic [7:0]  max_b_q;

  logic [7:0]  cur_a;
  logic [7:0]  cur_b;
  logic [15:0] exact_p;
  logic [15:0] ed;

  // The index is back at 0 outside RUN (cleared on start, wrapped at the end
  // of the sweep, cleared by reset), so the operands read 0 there for free.
  assign cur_a = idx[15:8];
  assign cur_b = idx[7:0];

  // Exact product and absolute error distance for the vector currently applied.
  always_comb begin
    exact_p = 16'(cur_a) * 16'(cur_b);
    if (exact_p >= bus.approx_y) ed = exact_p - bus.approx_y;
    else                         ed = bus.approx_y - exact_p;
  end

  // Sequencing FSM, stage-1 capture and stage-2 accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      s1_valid    <= 1'b0;
      s1_mis      <= 1'b0;
      s1_ed       <= '0;
      s1_a        <= '0;
      s1_b        <= '0;
      err_count_q <= '0;
      sum_ed_q    <= '0;
      max_ed_q    <= '0;
      max_a_q     <= '0;
      max_b_q     <= '0;
    end else begin
      // Stage 2: valid is only ever set in RUN and is cleared in DRAIN.
      if (s1_valid) begin
        err_count_q <= err_count_q + 17'(s1_mis);
        sum_ed_q    <= sum_ed_q + 32'(s1_ed);
        // Strict compare keeps the first worst vector in sweep order.
        if (s1_ed > max_ed_q) begin
          max_ed_q <= s1_ed;
          max_a_q  <= s1_a;
          max_b_q  <= s1_b;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state       <= RUN;
            idx         <= '0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            s1_valid    <= 1'b0;
            err_count_q <= '0;
            sum_ed_q    <= '0;
            max_ed_q    <= '0;
            max_a_q     <= '0;
            max_b_q     <= '0;
          end
        end
        RUN: begin
          s1_valid <= 1'b1;
          s1_mis   <= (bus.approx_y != exact_p);
          s1_ed    <= ed;
          s1_a     <= cur_a;
          s1_b     <= cur_b;
          idx      <= idx + 16'd1;
          if (idx == 16'hFFFF) state <= DRAIN;
        end
        DRAIN: begin
          s1_valid <= 1'b0;
          state    <= DONE;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.op_a      = cur_a;
  assign bus.op_b      = cur_b;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err_count = err_count_q;
  assign bus.sum_ed    = sum_ed_q;
  assign bus.max_ed    = max_ed_q;
  assign bus.max_a     = max_a_q;
  assign bus.max_b     = max_b_q;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Directed bench for approx_err_monitor. The bench models the multiplier
// under test combinationally from op_a/op_b in one of three flavours.
module tb_approx_err_monitor;
  logic clk;
  logic rst_n;
  int   mode;        // 0 exact, 1 stuck at zero, 2 LSB flipped
  int   n_checks;
  int   n_pass;

  approx_err_monitor_if bus_if ();

  approx_err_monitor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier under test.
  always_comb begin
    logic [15:0] p;
    p = 16'(bus_if.op_a) * 16'(bus_if.op_b);
    case (mode)
      1:       bus_if.approx_y = 16'd0;
      2:       bus_if.approx_y = p ^ 16'd1;
      default: bus_if.approx_y = p;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_results(input string tag, input logic [31:0] e_err, input logic [31:0] e_sum,
                               input logic [31:0] e_max, input logic [31:0] e_a, input logic [31:0] e_b);
    check({tag, "_err_count"}, 32'(bus_if.err_count), e_err);
    check({tag, "_sum_ed"},    bus_if.sum_ed,         e_sum);
    check({tag, "_max_ed"},    32'(bus_if.max_ed),    e_max);
    check({tag, "_max_a"},     32'(bus_if.max_a),     e_a);
    check({tag, "_max_b"},     32'(bus_if.max_b),     e_b);
  endtask

  // Start is sampled on the edge that follows; returns #1 after that edge.
  task automatic pulse_start();
    @(negedge clk);
    bus_if.start = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
  endtask

  // Counts edges after the start edge; done must first appear after edge 65537.
  task automatic run_sweep(input string tag, input int repulse_at);
    for (int e = 1; e <= 65536; e++) begin
      @(posedge clk);
      #1;
      if (repulse_at != 0 && e == repulse_at)     bus_if.start = 1'b1;
      if (repulse_at != 0 && e == repulse_at + 1) bus_if.start = 1'b0;
    end
    check({tag, "_done_at_65536"}, 32'(bus_if.done), 32'd0);
    check({tag, "_busy_drain"},    32'(bus_if.busy), 32'd1);
    @(posedge clk);
    #1;
    check({tag, "_done_at_65537"}, 32'(bus_if.done), 32'd1);
    check({tag, "_busy_done"},     32'(bus_if.busy), 32'd0);
    check({tag, "_op_a_done"},     32'(bus_if.op_a), 32'd0);
    check({tag, "_op_b_done"},     32'(bus_if.op_b), 32'd0);
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    mode         = 0;
    rst_n        = 1'b0;
    bus_if.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_done", 32'(bus_if.done), 32'd0);
    check("rst_op_a", 32'(bus_if.op_a), 32'd0);
    check_results("rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a sweep with the LSB-flip multiplier.
    mode = 2;
    pulse_start();
    check("abort_busy_next", 32'(bus_if.busy), 32'd1);
    repeat (100) @(posedge clk);
    #1;
    check("abort_op_b_100", 32'(bus_if.op_b), 32'd100);
    check("abort_err_pre",  32'(bus_if.err_count), 32'd99);
    check("abort_sum_pre",  bus_if.sum_ed, 32'd99);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus_if.busy), 32'd0);
    check("abort_done", 32'(bus_if.done), 32'd0);
    check("abort_op_b", 32'(bus_if.op_b), 32'd0);
    check_results("abort", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_restart", 32'(bus_if.busy), 32'd0);

    // Stuck-at-zero multiplier with an ignored start pulse at RUN cycle 1000.
    mode = 1;
    pulse_start();
    check("stuck_busy_next", 32'(bus_if.busy), 32'd1);
    run_sweep("stuck", 1000);
    check_results("stuck", 65025, 1065369600, 65025, 255, 255);
    repeat (5) @(posedge clk);
    #1;
    check("stuck_hold_done", 32'(bus_if.done), 32'd1);
    check_results("stuck_hold", 65025, 1065369600, 65025, 255, 255);

    // Restart from DONE with an exact multiplier.
    mode = 0;
    pulse_start();
    check("exact_busy_next", 32'(bus_if.busy), 32'd1);
    check("exact_done_clr",  32'(bus_if.done), 32'd0);
    check_results("exact_clr", 0, 0, 0, 0, 0);
    run_sweep("exact", 0);
    check_results("exact", 0, 0, 0, 0, 0);

    // LSB-flip multiplier: every vector off by one, first max at (0,0).
    mode = 2;
    pulse_start();
    run_sweep("lsb", 0);
    check_results("lsb", 65536, 65536, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
